// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame constants.
// The PARITY state is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int default_prescaler  = 16;
  localparam int default_data_width = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_e;

endpackage

// File: rtl/tx_serializer.sv
// Payload shift register plus bit counter for the UART transmitter.
// Loads a word, shifts it right one bit per shift_en, and flags the last bit.
module tx_serializer
  import uart_pkg::*;
#(
  parameter int data_width = default_data_width
) (
  input  logic                  clk2,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [data_width-1:0] data_in,
  output logic                  serial,
  output logic                  serial_next,
  output logic                  last_bit
);

  localparam int bit_w = (data_width > 1) ? $clog2(data_width) : 1;
  // With a one-bit payload there is never a following bit, so index 0 is a safe stand-in.
  localparam int next_idx = (data_width > 1) ? 1 : 0;

  logic [data_width-1:0] shreg;
  logic [bit_w-1:0]      bit_cnt;

  // Load the payload on acceptance, then shift LSB-first once per data bit.
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= data_in;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= shreg >> 1;
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

  assign serial      = shreg[0];
  // The bit that becomes serial after the next shift; lets the FSM register tx_out in step.
  assign serial_next = shreg[next_idx];
  assign last_bit    = (bit_cnt == bit_w'(data_width - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data_width payload bits LSB first, optional
// parity bit, stop bit; each bit lasts prescaler clk2 cycles.
// Optional parity is enabled with the macro UART_TX_PARITY_EN.
// Handshake: data_valid is sampled only in IDLE; when it is 1 at a clk2 edge the
// word on p_data is taken that same edge. There is no ready output: busy=1 means
// requests are dropped, including during the tx_done cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int prescaler  = default_prescaler,
  parameter int data_width = default_data_width
) (
  input  logic                  clk2,
  input  logic                  rst,
  input  logic [data_width-1:0] p_data,
  input  logic                  data_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                  par_typ,
`endif
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int cnt_w = (prescaler > 1) ? $clog2(prescaler) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(prescaler - 1);

  tx_state_e        state;
  tx_state_e        state_next;
  logic [cnt_w-1:0] edge_cnt;
  logic             bit_end;
  logic             tx_next;
  logic             load;
  logic             shift_en;
  logic             serial;
  logic             serial_next;
  logic             last_bit;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign bit_end = (edge_cnt == cnt_last);

  tx_serializer #(
    .data_width (data_width)
  ) u_serializer (
    .clk2        (clk2),
    .rst         (rst),
    .load        (load),
    .shift_en    (shift_en),
    .data_in     (p_data),
    .serial      (serial),
    .serial_next (serial_next),
    .last_bit    (last_bit)
  );

  // State, bit-timing counter and registered line/busy outputs.
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      tx_out   <= tx_next;
      busy     <= (state_next != IDLE);
      edge_cnt <= (state == IDLE || bit_end) ? '0 : edge_cnt + 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is computed once from the accepted word so later input changes cannot leak in.
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= (^p_data) ^ par_typ;
    end
  end
`endif

  // Next-state and next line level; tx_next is what tx_out shows from the next cycle.
  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    load       = 1'b0;
    shift_en   = 1'b0;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          state_next = START;
          load       = 1'b1;
          tx_next    = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          state_next = DATA;
          tx_next    = serial;
        end
      end
      DATA: begin
        tx_next = serial;
        if (bit_end) begin
          shift_en = 1'b1;
          if (last_bit) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_q;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            tx_next = serial_next;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_q;
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
